// File: rtl/fact_ctrl.sv
// ---------------------------------------------------------------------------
// fact_ctrl -- memory-mapped iterative factorial engine.
//
// A bus master writes an operand N, then writes GO. The engine computes N!
// one multiply per two cycles (CHECK/MULT loop) and posts the result in
// RESULT. Operands above MAX_N raise err instead of producing a result.
//
// Register map (a = dataadr[3:2]):
//   0 N      : wd[3:0] stored, reads {28'b0, N}
//   1 GO     : write wd[0]=1 starts, reads {31'b0, go}
//   2 STATUS : read-only {29'b0, busy, err, done}
//   3 RESULT : read-only, 32 bits
//
// Ports:
//   clk  in   1  clock, rising edge
//   rst  in   1  asynchronous reset, active low
//   we   in   1  register write strobe
//   a    in   2  register select
//   wd   in  32  write data
//   rd   out 32  read data, combinational on a
//   done out  1  result valid
//   err  out  1  operand exceeded MAX_N
//   busy out  1  computation in progress
// ---------------------------------------------------------------------------
module fact_ctrl #(
  parameter int MAX_N = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [1:0]  A_N      = 2'd0;
  localparam logic [1:0]  A_GO     = 2'd1;
  localparam logic [1:0]  A_STATUS = 2'd2;
  localparam logic [1:0]  A_RESULT = 2'd3;
  localparam logic [31:0] LP_MAX_N = MAX_N;

  state_t      r_state, w_next;
  logic [3:0]  r_n;       // bus-visible operand register
  logic [3:0]  r_op;      // operand frozen at LOAD for the range check
  logic [3:0]  r_cnt;
  logic [31:0] r_prod;
  logic [31:0] r_result;
  logic        r_go;

  logic        w_busy;
  logic        w_go_wr;
  logic        w_n_wr;
  logic        w_op_big;

  assign w_busy   = (r_state == LOAD) || (r_state == CHECK) || (r_state == MULT);
  assign w_n_wr   = we && (a == A_N);
  // GO is only accepted while idle; a GO during a run is dropped entirely.
  assign w_go_wr  = we && (a == A_GO) && wd[0] && !w_busy;
  assign w_op_big = {28'd0, r_op} > LP_MAX_N;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: if (w_go_wr) w_next = LOAD;
      LOAD:            w_next = CHECK;
      CHECK: begin
        if (w_op_big)           w_next = ERR;
        else if (r_cnt <= 4'd1) w_next = DONE;
        else                    w_next = MULT;
      end
      MULT:            w_next = CHECK;
      default:         w_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers / datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_prod   <= 32'd1;
      r_result <= '0;
      r_go     <= 1'b0;
    end else begin
      // N is writable at any time; an in-flight run uses r_op, not r_n.
      if (w_n_wr) r_n <= wd[3:0];

      if (w_go_wr)               r_go <= 1'b1;
      else if (r_state == LOAD)  r_go <= 1'b0;

      unique case (r_state)
        LOAD: begin
          r_cnt  <= r_n;
          r_op   <= r_n;
          r_prod <= 32'd1;
        end
        CHECK: begin
          // RESULT only changes on entry to DONE/ERR, so it holds its
          // previous value for the whole run.
          if (w_next == DONE)     r_result <= r_prod;
          else if (w_next == ERR) r_result <= '0;
        end
        MULT: begin
          r_prod <= r_prod * {28'd0, r_cnt};
          r_cnt  <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy = w_busy;
  assign done = (r_state == DONE);
  assign err  = (r_state == ERR);

  always_comb begin
    rd = '0;
    unique case (a)
      A_N:      rd = {28'd0, r_n};
      A_GO:     rd = {31'd0, r_go};
      A_STATUS: rd = {29'd0, busy, err, done};
      A_RESULT: rd = r_result;
      default:  rd = '0;
    endcase
  end

endmodule

// File: doc/fact_ctrl.md
FACT_CTRL -- requirements
Module: fact_ctrl

Interface
REQ-001 SHALL have parameter MAX_N, default 12: largest operand whose factorial fits 32 bits; larger operands raise an error.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port we, input, 1: register write strobe from the bus decoder.
REQ-005 SHALL have port a, input, 2: register select, driven by dataadr[3:2].
REQ-006 SHALL have port wd, input, 32: write data.
REQ-007 SHALL have port rd, output, 32: read data, combinational on a.
REQ-008 SHALL have port done, output, 1: result valid.
REQ-009 SHALL have port err, output, 1: operand exceeded MAX_N.
REQ-010 SHALL have port busy, output, 1: computation in progress.

Function
REQ-011 SHALL implement the register map: a=0 N (wd[3:0] stored, reads {28'b0,N}); a=1 GO (write wd[0]=1 starts, reads {31'b0,go}); a=2 STATUS (read-only {29'b0,busy,err,done}); a=3 RESULT (read-only, 32 bits).
REQ-012 SHALL use FSM states IDLE, LOAD, CHECK, MULT, DONE, ERR.
REQ-013 SHALL, in IDLE/DONE/ERR, on we=1, a=1, wd[0]=1, enter LOAD on the same edge; go reg set to 1.
REQ-014 SHALL, in LOAD: cnt<=N, prod<=1, done<=0, err<=0, go<=0; next state CHECK.
REQ-015 SHALL, in CHECK: if the latched operand > MAX_N -> ERR; else if cnt<=1 -> DONE; else -> MULT.
REQ-016 SHALL, in MULT: prod<=prod*cnt (low 32 bits), cnt<=cnt-1; next state CHECK.
REQ-017 SHALL, on DONE entry: RESULT<=prod, done=1; on ERR entry: RESULT<=0, err=1; both hold until the next GO.
REQ-018 SHALL assert busy exactly in LOAD, CHECK and MULT.
REQ-019 SHALL make done visible 2*max(N,1)+1 rising edges after the GO write edge, and err 3 edges after it.
REQ-020 SHALL ignore GO writes while busy=1; the go reg stays 0 and the computation is unaffected.
REQ-021 SHALL accept N writes at any time; writes during busy affect only the next GO, since the operand is latched in LOAD.
REQ-022 SHALL leave RESULT holding its previous value while busy=1.
REQ-023 SHALL treat writes to a=2 and a=3 as no-ops.
REQ-024 SHALL treat N=0 as 0!=1.
REQ-025 SHALL give priority to GO when N and GO are written on different cycles with no gap; the GO edge uses the N value already stored.

Reset
REQ-026 SHALL, while rst=0, immediately force: state IDLE, N=0, go=0, cnt=0, prod=1, RESULT=0, done=0, err=0, busy=0, regardless of clk.
REQ-027 SHALL, on reset mid-computation, abandon it with no partial RESULT update.
REQ-028 SHALL require a new GO after rst deasserts; no computation starts by itself.

Verification
REQ-029 SHALL cover: write N=5, GO=1 -> busy for 10 edges, done=1 on edge 11, RESULT=120 (0x78), STATUS=0x1.
REQ-030 SHALL cover: N=0 then GO, and separately N=1 then GO -> done at edge 3, RESULT=1.
REQ-031 SHALL cover: N=12 then GO -> done at edge 25, RESULT=479001600 (0x1C8CFC00); N=13 then GO -> err=1 at edge 3, RESULT=0, STATUS=0x2.
REQ-032 SHALL cover: N=6 then GO; at edge 4 write N=3 and GO -> GO ignored, RESULT=720; a following GO yields 6.
REQ-033 SHALL cover: N=10 then GO; rst=0 at edge 5 -> all outputs 0 immediately, RESULT=0; after release with no GO, state stays IDLE.
REQ-034 SHALL cover: after a completed run, issue GO with N=4 -> done drops to 0 at LOAD and rises with RESULT=24 at edge 9.
